// File: rtl/deser_rx_32_if.sv
// deser_rx_32_if: serial-in and word-out signals of the deserialiser.
// par_err exists only when PARITY_CHK_EN is defined.
interface deser_rx_32_if #(parameter int WIDTH = 32);
   logic             s_in32;
   logic             s_vld32;
   logic             dir32;
   logic             flush32;
   logic             clr_ovf;
   logic             q_rdy32;
   logic [WIDTH-1:0] q32;
   logic             q_vld32;
   logic             ovf32;
`ifdef PARITY_CHK_EN
   logic             par_err;
`endif
   modport master (
      output s_in32, s_vld32, dir32, flush32, clr_ovf, q_rdy32,
      input  q32, q_vld32, ovf32
`ifdef PARITY_CHK_EN
      , input par_err
`endif
   );
   modport slave (
      input  s_in32, s_vld32, dir32, flush32, clr_ovf, q_rdy32,
      output q32, q_vld32, ovf32
`ifdef PARITY_CHK_EN
      , output par_err
`endif
   );
endinterface

// File: rtl/deser_rx_32.sv
// deser_rx_32: serial-to-parallel receiver with valid/ready word output and sticky overrun.
// Define PARITY_CHK_EN to expect an even-parity bit after each word and report par_err.
module deser_rx_32 #(
   parameter int WIDTH = 32
) (
   input logic           clk32,
   input logic           rstn32,
   deser_rx_32_if.slave  rx
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   typedef enum logic [1:0] {SHIFT, PAR, HOLD} state_t;
   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] nxt;
   logic             q_vld;
   logic             ovf;
   logic             dir_l;
   logic             eff_dir;
`ifdef PARITY_CHK_EN
   logic             par_err;
   assign rx.par_err = par_err;
`endif
   // A new frame (cnt==0, also the case in HOLD) shifts with the live dir32, later bits with the latched one
   always_comb begin
      eff_dir = (cnt == '0) ? rx.dir32 : dir_l;
      nxt = eff_dir ? {rx.s_in32, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], rx.s_in32};
   end
   always_ff @(posedge clk32 or negedge rstn32) begin
      if (!rstn32) begin
         state <= SHIFT;
         cnt   <= '0;
         sr    <= '0;
         q_vld <= 1'b0;
         ovf   <= 1'b0;
         dir_l <= 1'b0;
`ifdef PARITY_CHK_EN
         par_err <= 1'b0;
`endif
      end else if (rx.flush32) begin
         state <= SHIFT;
         cnt   <= '0;
         q_vld <= 1'b0;
`ifdef PARITY_CHK_EN
         par_err <= 1'b0;
`endif
      end else begin
         ovf <= (state == HOLD && rx.s_vld32 && !rx.q_rdy32) | (ovf & ~rx.clr_ovf);
         case (state)
            SHIFT: if (rx.s_vld32) begin
               if (cnt == '0) dir_l <= rx.dir32;
               sr  <= nxt;
               cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
               if (cnt == LAST) begin
`ifdef PARITY_CHK_EN
                  state <= PAR;
`else
                  state <= HOLD;
                  q_vld <= 1'b1;
`endif
               end
            end
`ifdef PARITY_CHK_EN
            PAR: if (rx.s_vld32) begin
               par_err <= ^{sr, rx.s_in32};
               q_vld   <= 1'b1;
               state   <= HOLD;
            end
`endif
            HOLD: if (rx.q_rdy32) begin
               q_vld <= 1'b0;
               state <= SHIFT;
`ifdef PARITY_CHK_EN
               par_err <= 1'b0;
`endif
               // Retiring and accepting the next frame's first bit on the same edge avoids a bubble
               if (rx.s_vld32) begin
                  dir_l <= rx.dir32;
                  sr    <= nxt;
                  cnt   <= CW'(1);
               end
            end
            default: state <= SHIFT;
         endcase
      end
   end
   assign rx.q32    = sr;
   assign rx.q_vld32 = q_vld;
   assign rx.ovf32  = ovf;
endmodule

// File: tb/tb_deser_rx_32.sv
// tb_deser_rx_32: directed frames with a word scoreboard and a probe queue checked by one monitor.
// Build with PARITY_CHK_EN defined to exercise parity frames as well.
module tb_deser_rx_32;
   logic clk32 = 1'b0;
   logic rstn32 = 1'b0;
   deser_rx_32_if #(.WIDTH(32)) rx();
   deser_rx_32 #(.WIDTH(32)) dut (.clk32(clk32), .rstn32(rstn32), .rx(rx));
   always #5 clk32 = ~clk32;
   typedef struct {logic [31:0] w; logic pe;} exp_t;
   typedef struct {int kind; logic [31:0] v; string name;} probe_t;
   exp_t   sb[$];
   probe_t pq[$];
   exp_t   mon_e;
   probe_t mon_p;
   logic [31:0] act;
   int vectors = 0;
   int miscompares = 0;
   // Words are compared on each accepted handshake; probes requested by the driver are compared in the same half-cycle
   always @(negedge clk32) begin
      if (rx.q_vld32 && rx.q_rdy32) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_word: got %h, scoreboard empty", rx.q32);
         end else begin
            mon_e = sb.pop_front();
            if (rx.q32 !== mon_e.w) begin
               miscompares++;
               $display("FAIL word: got %h, expected %h", rx.q32, mon_e.w);
            end
`ifdef PARITY_CHK_EN
            vectors++;
            if (rx.par_err !== mon_e.pe) begin
               miscompares++;
               $display("FAIL par_err_word %h: got %b, expected %b", mon_e.w, rx.par_err, mon_e.pe);
            end
`endif
         end
      end
      while (pq.size() > 0) begin
         mon_p = pq.pop_front();
         act = mon_p.kind == 0 ? 32'(rx.q_vld32) :
               mon_p.kind == 1 ? 32'(rx.ovf32) :
               mon_p.kind == 2 ? rx.q32 :
`ifdef PARITY_CHK_EN
               mon_p.kind == 3 ? 32'(rx.par_err) :
`endif
               32'(sb.size());
         vectors++;
         if (act !== mon_p.v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", mon_p.name, act, mon_p.v);
         end
      end
   end
   task automatic tick();
      @(posedge clk32);
      #1;
   endtask
   task automatic probe(int k, logic [31:0] v, string n);
      probe_t p;
      p.kind = k;
      p.v = v;
      p.name = n;
      pq.push_back(p);
   endtask
   task automatic push(logic [31:0] w, logic pe);
      exp_t e;
      e.w = w;
      e.pe = pe;
      sb.push_back(e);
   endtask
   task automatic send_bit(logic b, logic d);
      rx.s_in32 = b;
      rx.dir32 = d;
      rx.s_vld32 = 1'b1;
      tick();
      rx.s_vld32 = 1'b0;
   endtask
   task automatic send_range(logic [31:0] w, logic d, int gap, int lo, int hi);
      for (int i = lo; i <= hi; i++) begin
         send_bit(d ? w[i] : w[31-i], d);
         repeat ($urandom_range(0, gap)) tick();
      end
   endtask
   task automatic send_word(logic [31:0] w, logic d, int gap);
      send_range(w, d, gap, 0, 31);
`ifdef PARITY_CHK_EN
      send_bit(^w, d);
`endif
   endtask
   initial begin
      rx.s_in32 = 1'b0;
      rx.s_vld32 = 1'b0;
      rx.dir32 = 1'b0;
      rx.flush32 = 1'b0;
      rx.clr_ovf = 1'b0;
      rx.q_rdy32 = 1'b1;
      tick();
      probe(0, 0, "rst_q_vld");
      probe(1, 0, "rst_ovf");
      probe(2, 0, "rst_q32");
      tick();
      rstn32 = 1'b1;
      tick();
      // MSB first, back-to-back, latency of q_vld
      push(32'hA5C3_0F1E, 1'b0);
      send_range(32'hA5C3_0F1E, 1'b0, 0, 0, 30);
      probe(0, 0, "vld_before_last");
      send_range(32'hA5C3_0F1E, 1'b0, 0, 31, 31);
`ifdef PARITY_CHK_EN
      send_bit(^32'hA5C3_0F1E, 1'b0);
`endif
      probe(0, 1, "vld_latency");
      tick();
      probe(0, 0, "vld_after_retire");
      // LSB first with gaps
      push(32'h8000_0001, 1'b0);
      send_word(32'h8000_0001, 1'b1, 3);
      tick();
      // overrun while held; set beats clear
      rx.q_rdy32 = 1'b0;
      push(32'h0F0F_55AA, 1'b0);
      send_word(32'h0F0F_55AA, 1'b0, 0);
      probe(0, 1, "held_vld");
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      rx.clr_ovf = 1'b1;
      send_bit(1'b1, 1'b0);
      rx.clr_ovf = 1'b0;
      probe(1, 1, "ovf_set_wins");
      probe(2, 32'h0F0F_55AA, "held_word_unchanged");
      rx.q_rdy32 = 1'b1;
      tick();
      probe(0, 0, "ovf_retire_vld");
      probe(1, 1, "ovf_sticky");
      rx.clr_ovf = 1'b1;
      tick();
      rx.clr_ovf = 1'b0;
      probe(1, 0, "ovf_cleared");
      // two words back-to-back, retire coincides with first bit of the next
      push(32'h1111_2222, 1'b0);
      push(32'h3333_CCCC, 1'b0);
      send_word(32'h1111_2222, 1'b0, 0);
      send_word(32'h3333_CCCC, 1'b1, 0);
      probe(1, 0, "no_ovf_b2b");
      tick();
      // flush after 17 bits, then a clean word
      send_range(32'hFFFF_FFFF, 1'b0, 0, 0, 16);
      rx.flush32 = 1'b1;
      rx.s_vld32 = 1'b1;
      rx.s_in32 = 1'b1;
      tick();
      rx.flush32 = 1'b0;
      rx.s_vld32 = 1'b0;
      probe(0, 0, "flush_partial_vld");
      push(32'h1234_5678, 1'b0);
      send_word(32'h1234_5678, 1'b0, 0);
      tick();
      // flush of a held word keeps ovf
      rx.q_rdy32 = 1'b0;
      send_word(32'hCAFE_F00D, 1'b0, 0);
      send_bit(1'b1, 1'b0);
      rx.flush32 = 1'b1;
      tick();
      rx.flush32 = 1'b0;
      probe(0, 0, "flush_held_vld");
      probe(1, 1, "ovf_kept_by_flush");
      // asynchronous reset mid-frame
      rx.q_rdy32 = 1'b1;
      send_range(32'h5A5A_5A5A, 1'b0, 0, 0, 9);
      rstn32 = 1'b0;
      probe(0, 0, "async_rst_vld");
      probe(1, 0, "async_rst_ovf");
      probe(2, 0, "async_rst_q32");
      tick();
      rstn32 = 1'b1;
      tick();
`ifdef PARITY_CHK_EN
      push(32'h0000_0007, 1'b0);
      send_range(32'h0000_0007, 1'b0, 0, 0, 31);
      send_bit(1'b1, 1'b0);
      probe(3, 0, "par_ok");
      tick();
      push(32'h0000_0007, 1'b1);
      send_range(32'h0000_0007, 1'b0, 0, 0, 31);
      send_bit(1'b0, 1'b0);
      probe(3, 1, "par_bad");
      probe(0, 1, "par_bad_vld");
      tick();
      probe(3, 0, "par_cleared");
`endif
      tick();
      tick();
      probe(4, 0, "scoreboard_drained");
      @(negedge clk32);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
